// File: rtl/data_mem_port_pkg.sv
// Shared encodings for the data-memory port: access sizes, register-file
// write codes for loads, and the port FSM state type.
package data_mem_port_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  localparam logic [2:0] WE3_NONE = 3'b000;
  localparam logic [2:0] WE3_LW   = 3'b001;
  localparam logic [2:0] WE3_LH   = 3'b010;
  localparam logic [2:0] WE3_LB   = 3'b011;
  localparam logic [2:0] WE3_LHU  = 3'b110;
  localparam logic [2:0] WE3_LBU  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  function automatic logic [2:0] load_we3(input size_e size, input logic uns);
    case (size)
      SIZE_WORD: load_we3 = WE3_LW;
      SIZE_HALF: load_we3 = uns ? WE3_LHU : WE3_LH;
      SIZE_BYTE: load_we3 = uns ? WE3_LBU : WE3_LB;
      default:   load_we3 = WE3_NONE;
    endcase
  endfunction

  function automatic logic is_aligned(input size_e size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: is_aligned = 1'b1;
      SIZE_HALF: is_aligned = ~offset[0];
      SIZE_WORD: is_aligned = (offset == 2'b00);
      default:   is_aligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_port_lane_align.sv
// Byte-lane steering: store strobes/data replication and load data shift.
module lane_align
  import data_mem_port_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_shifted
);

  always_comb begin
    wstrb       = '0;
    wdata_lanes = wdata;
    case (size)
      SIZE_BYTE: begin
        wstrb       = 4'b0001 << offset;
        wdata_lanes = {4{wdata[7:0]}};
      end
      SIZE_HALF: begin
        wstrb       = 4'b0011 << offset;
        wdata_lanes = {2{wdata[15:0]}};
      end
      SIZE_WORD: wstrb = 4'b1111;
      default:   wstrb = '0;
    endcase
    // Word accesses are aligned, so one shift serves all legal sizes.
    rdata_shifted = rdata >> {offset, 3'b000};
  end

endmodule

// File: rtl/data_mem_port.sv
// Load/store unit port: accepts one execute-stage access, issues it to memory
// with byte-lane steering, and returns a one-cycle completion pulse.
module data_mem_port
  import data_mem_port_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [3:0]            mem_wstrb,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [4:0]            rsp_rd,
  output logic [2:0]            rsp_we3,
  output logic                  rsp_err,
  output logic                  busy
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  size_e                 size_q, size_d;
  logic                  we_q, we_d;
  logic                  uns_q, uns_d;
  logic [4:0]            rd_q, rd_d;

  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [4:0]            rsp_rd_q, rsp_rd_d;
  logic [2:0]            rsp_we3_q, rsp_we3_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [3:0]            strb;
  logic [DATA_WIDTH-1:0] wdata_lanes;
  logic [DATA_WIDTH-1:0] rdata_shifted;
  logic                  load_done;

  lane_align u_lane_align (
    .size          (size_q),
    .offset        (addr_q[1:0]),
    .wdata         (wdata_q),
    .rdata         (mem_rdata),
    .wstrb         (strb),
    .wdata_lanes   (wdata_lanes),
    .rdata_shifted (rdata_shifted)
  );

  // Memory side is decoded from captured registers, so it cannot move while ISSUE waits.
  assign mem_valid = (state_q == ST_ISSUE);
  assign mem_addr  = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign mem_we    = mem_valid & we_q;
  assign mem_wstrb = mem_we ? strb : '0;
  assign mem_wdata = wdata_lanes;

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_rd    = rsp_rd_q;
  assign rsp_we3   = rsp_we3_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    we_d        = we_q;
    uns_d       = uns_q;
    rd_d        = rd_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = '0;
    rsp_rd_d    = '0;
    rsp_we3_d   = WE3_NONE;
    rsp_err_d   = 1'b0;
    load_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = size_e'(req_size);
          we_d    = req_we;
          uns_d   = req_unsigned;
          rd_d    = req_rd;
          if (is_aligned(size_e'(req_size), req_addr[1:0])) begin
            state_d = ST_ISSUE;
          end else begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rd_d    = req_rd;
          end
        end
      end
      ST_ISSUE: begin
        if (mem_ready) begin
          if (we_q) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_rd_d    = rd_q;
          end else if (mem_rvalid) begin
            load_done = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) load_done = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (load_done) begin
      state_d     = ST_RESP;
      rsp_valid_d = 1'b1;
      rsp_data_d  = rdata_shifted;
      rsp_rd_d    = rd_q;
      rsp_we3_d   = load_we3(size_q, uns_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= SIZE_BYTE;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      rd_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_rd_q    <= '0;
      rsp_we3_q   <= WE3_NONE;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      we_q        <= we_d;
      uns_q       <= uns_d;
      rd_q        <= rd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_we3_q   <= rsp_we3_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_data_mem_port.sv
// Directed bench for data_mem_port with hand-computed expectations.
module tb_data_mem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        rsp_valid, rsp_err, busy;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic [2:0]  rsp_we3;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  data_mem_port #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
    .rsp_we3(rsp_we3), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single cycle; returns just after the accepting edge.
  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; req_rd = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    tick(); tick();
    rst = 1'b0;

    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_we",    32'(mem_we),    32'd0);
    check("rst_wstrb",     32'(mem_wstrb), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check("rst_we3",       32'(rsp_we3),   32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_ready",     32'(req_ready), 32'd1);

    // sb to 0x103
    send(1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_00AB, 5'd4);
    check("sb_mem_valid", 32'(mem_valid), 32'd1);
    check("sb_mem_addr",  mem_addr,       32'h100);
    check("sb_wstrb",     32'(mem_wstrb), 32'b1000);
    check("sb_wdata",     mem_wdata,      32'hABAB_ABAB);
    check("sb_mem_we",    32'(mem_we),    32'd1);
    check("sb_ready_lo",  32'(req_ready), 32'd0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("sb_rsp_valid", 32'(rsp_valid), 32'd1);
    check("sb_we3",       32'(rsp_we3),   32'd0);
    check("sb_err",       32'(rsp_err),   32'd0);
    check("sb_mem_idle",  32'(mem_valid), 32'd0);
    tick();
    check("sb_pulse_end", 32'(rsp_valid), 32'd0);
    check("sb_ready_hi",  32'(req_ready), 32'd1);

    // lh from 0x202 with a separate read response
    send(1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 5'd5);
    check("lh_mem_addr", mem_addr,       32'h200);
    check("lh_wstrb",    32'(mem_wstrb), 32'd0);
    check("lh_mem_we",   32'(mem_we),    32'd0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("lh_wait_no_rsp", 32'(rsp_valid), 32'd0);
    check("lh_wait_busy",   32'(busy),      32'd1);
    check("lh_wait_no_mem", 32'(mem_valid), 32'd0);
    tick();
    check("lh_still_wait", 32'(rsp_valid), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h8001_1234;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    check("lh_rsp_valid", 32'(rsp_valid), 32'd1);
    check("lh_rsp_data",  rsp_data,       32'h0000_8001);
    check("lh_we3",       32'(rsp_we3),   32'b010);
    check("lh_rd",        32'(rsp_rd),    32'd5);
    tick();
    check("lh_rsp_clear", rsp_data, 32'd0);

    // lbu from 0x301, ready and rvalid together
    send(1'b0, 2'b00, 1'b1, 32'h301, 32'h0, 5'd7);
    check("lbu_no_rsp_c1", 32'(rsp_valid), 32'd0);
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0000_F000;
    tick();
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    check("lbu_rsp_valid", 32'(rsp_valid), 32'd1);
    check("lbu_rsp_data",  rsp_data,       32'h0000_00F0);
    check("lbu_we3",       32'(rsp_we3),   32'b111);
    check("lbu_rd",        32'(rsp_rd),    32'd7);
    tick();

    // misaligned lw at 0x102
    send(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 5'd9);
    check("mis_mem_valid", 32'(mem_valid), 32'd0);
    check("mis_rsp_valid", 32'(rsp_valid), 32'd1);
    check("mis_err",       32'(rsp_err),   32'd1);
    check("mis_we3",       32'(rsp_we3),   32'd0);
    check("mis_rd",        32'(rsp_rd),    32'd9);
    tick();
    check("mis_err_clear", 32'(rsp_err), 32'd0);

    // reserved size is always an error
    send(1'b1, 2'b11, 1'b0, 32'h100, 32'h0, 5'd1);
    check("rsvd_err",       32'(rsp_err),   32'd1);
    check("rsvd_mem_valid", 32'(mem_valid), 32'd0);
    tick();

    // sh at 0x002 with memory stalled for 5 cycles
    send(1'b1, 2'b01, 1'b0, 32'h002, 32'h1234_5678, 5'd2);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(mem_valid), 32'd1);
      check("stall_addr",  mem_addr,       32'h0);
      check("stall_wstrb", 32'(mem_wstrb), 32'b1100);
      check("stall_wdata", mem_wdata,      32'h5678_5678);
      check("stall_busy",  32'(busy),      32'd1);
      tick();
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("stall_rsp", 32'(rsp_valid), 32'd1);
    tick();

    // aligned lw, reset while waiting, late rvalid must be ignored
    send(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 5'd3);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("rw_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rw_ready",  32'(req_ready), 32'd1);
    check("rw_busy0",  32'(busy),      32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    check("rw_no_rsp",   32'(rsp_valid), 32'd0);
    check("rw_ready2",   32'(req_ready), 32'd1);
    tick();
    check("rw_no_rsp2",  32'(rsp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule
